// File: rtl/instruction_decode_controller.sv
// rtl/instruction_decode_controller.sv - fetch/decode/dispatch FSM driving the add controller.
// Optional build macro ADD_WATCHDOG_EN adds a 255-cycle add_done watchdog in WAIT_DONE.
module instruction_decode_controller #(
   parameter int WORD_SIZE              = 32,
   parameter int NUMBER_OF_REGISTERS    = 32,
   parameter int NUMBER_OF_PC_REGISTERS = 256,
   parameter int OPERATION_TYPE_WIDTH   = 2,
   localparam int ADDR_WIDTH            = $clog2(NUMBER_OF_REGISTERS),
   localparam int PC_WIDTH              = $clog2(NUMBER_OF_PC_REGISTERS)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            run,
   output logic [PC_WIDTH-1:0]             imem_addr,
   input  logic [WORD_SIZE-1:0]            imem_data,
   output logic [PC_WIDTH-1:0]             pc,
   output logic                            add_start,
   output logic [OPERATION_TYPE_WIDTH-1:0] add_operation_type,
   output logic [PC_WIDTH-1:0]             add_pc,
   output logic [ADDR_WIDTH-1:0]           add_source_1_address,
   output logic [ADDR_WIDTH-1:0]           add_source_2_address,
   output logic [ADDR_WIDTH-1:0]           add_destination_address,
   output logic [WORD_SIZE-1:0]            add_immediate_value,
   input  logic [PC_WIDTH-1:0]             add_next_pc,
   input  logic                            add_busy,
   input  logic                            add_done,
   output logic                            halted,
   output logic                            error,
   output logic [15:0]                     retired_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_DECODE,
      S_DISPATCH,
      S_WAIT_DONE,
      S_HALTED
   } state_t;

   localparam logic [5:0] OP_NOP  = 6'h00;
   localparam logic [5:0] OP_ADD  = 6'h01;
   localparam logic [5:0] OP_ADDI = 6'h02;
   localparam logic [5:0] OP_HALT = 6'h3F;

   state_t               state;
   logic [WORD_SIZE-1:0] ir;
   logic [5:0]           opcode;
`ifdef ADD_WATCHDOG_EN
   logic [7:0]           wd_cnt;
`endif

   assign opcode    = ir[31:26];
   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state                   <= S_IDLE;
         ir                      <= '0;
         pc                      <= '0;
         add_start               <= 1'b0;
         add_operation_type      <= '0;
         add_pc                  <= '0;
         add_source_1_address    <= '0;
         add_source_2_address    <= '0;
         add_destination_address <= '0;
         add_immediate_value     <= '0;
         halted                  <= 1'b0;
         error                   <= 1'b0;
         retired_count           <= '0;
`ifdef ADD_WATCHDOG_EN
         wd_cnt                  <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (run) state <= S_FETCH;
            end
            S_FETCH: state <= S_LATCH;
            S_LATCH: begin
               ir    <= imem_data;
               state <= S_DECODE;
            end
            S_DECODE: begin
               case (opcode)
                  OP_ADD, OP_ADDI: begin
                     add_operation_type      <= (opcode == OP_ADDI) ? OPERATION_TYPE_WIDTH'(1) : '0;
                     add_pc                  <= pc;
                     add_destination_address <= ADDR_WIDTH'(ir[25:21]);
                     add_source_1_address    <= ADDR_WIDTH'(ir[20:16]);
                     add_source_2_address    <= ADDR_WIDTH'(ir[15:11]);
                     add_immediate_value     <= {ir[15:0], 16'h0000};
                     // Pre-arm the pulse so it lands in the first DISPATCH cycle when the adder is free.
                     add_start               <= !add_busy;
                     state                   <= S_DISPATCH;
                  end
                  OP_NOP: begin
                     pc            <= pc + PC_WIDTH'(1);
                     retired_count <= retired_count + 16'd1;
                     state         <= run ? S_FETCH : S_IDLE;
                  end
                  OP_HALT: begin
                     halted        <= 1'b1;
                     retired_count <= retired_count + 16'd1;
                     state         <= S_HALTED;
                  end
                  default: begin
                     error  <= 1'b1;
                     halted <= 1'b1;
                     state  <= S_HALTED;
                  end
               endcase
            end
            S_DISPATCH: begin
               if (add_start) begin
                  add_start <= 1'b0;
                  state     <= S_WAIT_DONE;
`ifdef ADD_WATCHDOG_EN
                  wd_cnt    <= '0;
`endif
               end else if (!add_busy) begin
                  add_start <= 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (add_done && !add_busy) begin
                  pc            <= add_next_pc;
                  retired_count <= retired_count + 16'd1;
                  state         <= run ? S_FETCH : S_IDLE;
               end
`ifdef ADD_WATCHDOG_EN
               // Count 254 marks the 255th cycle spent waiting without a done.
               else if (wd_cnt == 8'd254) begin
                  error  <= 1'b1;
                  halted <= 1'b1;
                  state  <= S_HALTED;
               end else begin
                  wd_cnt <= wd_cnt + 8'd1;
               end
`endif
            end
            S_HALTED: state <= S_HALTED;
            default:  state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/instruction_decode_controller.md
# instruction_decode_controller

Fetches 32-bit instruction words from a synchronous instruction ROM, decodes them, and dispatches ADD/ADDI operations to the downstream add controller over a start/busy/done handshake. It owns the architectural program counter and adopts the add controller's `next_pc` on completion. It sits between instruction memory and the add controller, and tracks halt, error and retired-instruction status.

## Interface
- `WORD_SIZE`, default 32: instruction and operand width.
- `NUMBER_OF_REGISTERS`, default 32: register-file depth. `ADDR_WIDTH` = $clog2 of this.
- `NUMBER_OF_PC_REGISTERS`, default 256: instruction ROM depth. `PC_WIDTH` = $clog2 of this.
- `OPERATION_TYPE_WIDTH`, default 2: width of the R/I type code.

Ports:
- `clk` in 1: clock; all logic on posedge.
- `rst` in 1: synchronous, active-low reset.
- `run` in 1: level; starts or continues execution from IDLE.
- `imem_addr` out PC_WIDTH: ROM address; combinationally equal to `pc`.
- `imem_data` in WORD_SIZE: ROM data, valid one cycle after the address.
- `pc` out PC_WIDTH: architectural PC; reset 0.
- `add_start` out 1: one-cycle dispatch pulse; reset 0.
- `add_operation_type` out OPERATION_TYPE_WIDTH: 0 = R, 1 = I; reset 0.
- `add_pc` out PC_WIDTH: PC of the dispatched instruction; reset 0.
- `add_source_1_address`, `add_source_2_address`, `add_destination_address` out ADDR_WIDTH: rs1, rs2, rd; reset 0.
- `add_immediate_value` out WORD_SIZE: `{imm16, 16'h0000}`; reset 0.
- `add_next_pc` in PC_WIDTH, `add_busy` in 1, `add_done` in 1: add controller status.
- `halted` out 1: sticky; set by HALT or error; reset 0.
- `error` out 1: sticky; illegal opcode or watchdog; reset 0.
- `retired_count` out 16: instructions completed; reset 0.

## Operation
- Encoding: [31:26] opcode, [25:21] rd, [20:16] rs1, [15:11] rs2, [15:0] imm16. Register fields are truncated to ADDR_WIDTH.
- Opcodes:
  - 6'h00 NOP: pc+1.
  - 6'h01 ADD: R-type dispatch.
  - 6'h02 ADDI: I-type dispatch.
  - 6'h3F HALT.
  - All other opcodes are illegal.
- States:
  - IDLE: leave when `run`=1 → FETCH.
  - FETCH: ROM is addressed with `pc` → LATCH.
  - LATCH: `ir <= imem_data` → DECODE.
  - DECODE:
    - ADD/ADDI: register all `add_*` fields → DISPATCH.
    - NOP: pc+1, retired+1 → FETCH if `run`, else IDLE.
    - HALT: `halted`=1, retired+1, pc unchanged → HALTED.
    - Illegal: `error`=1, `halted`=1 → HALTED.
  - DISPATCH: `add_start`=1 for exactly one cycle, only if `add_busy`=0; otherwise wait in DISPATCH with `add_start`=0 → WAIT_DONE.
  - WAIT_DONE: on `add_done`=1 with `add_busy`=0: `pc <= add_next_pc`, retired+1 → FETCH if `run`, else IDLE.
  - HALTED: terminal; exit only by reset.
- `add_done` is a level that stays high until the next start. It is sampled only in WAIT_DONE, and that state is never entered in the same cycle as the start pulse, so a stale done is never seen.
- PC arithmetic is modulo 2^PC_WIDTH; NOP at pc = NUMBER_OF_PC_REGISTERS-1 wraps to 0.
- `retired_count` wraps 16'hFFFF → 0.
- Reset mid-operation: all state and outputs return to reset values; the add controller is reset by the same system reset.

## Timing
- Fetch-to-dispatch: FETCH, LATCH, DECODE, then `add_start` is high in the 4th cycle after entering FETCH.
- The ADD/ADDI loop costs 4 cycles plus the add controller's latency. NOP costs 3 cycles. HALT takes effect at the DECODE edge.
- `add_*` fields are stable from DECODE until the next DECODE.
- `pc` updates on the same edge that retires the instruction. The next FETCH presents the new address the following cycle.
- `run` dropping during WAIT_DONE finishes the current instruction, then goes to IDLE.

## Configuration
- `ADD_WATCHDOG_EN` defined:
  - An 8-bit counter clears on entry to WAIT_DONE.
  - If `add_done` is not seen within 255 cycles: `error`=1, `halted`=1 → HALTED; pc unchanged.
- `ADD_WATCHDOG_EN` undefined: no counter; WAIT_DONE waits indefinitely.

## Test plan
- ROM[0]=0x04611000 (ADD r3,r1,r2), ROM[1]=0xFC000000, `run`=1; model done 10 cycles after start → `add_start` one pulse with rs1=1, rs2=2, rd=3, type=0, add_pc=0; pc=1, then halted=1, retired_count=2, error=0.
- ROM[0]=0x08814000 (ADDI r4,r1,0x4000) → type=1, `add_immediate_value`=0x40000000, rd=4, rs1=1.
- ROM[0]=0x14000000 (opcode 0x05) → error=1, halted=1, pc=0, no `add_start`.
- NUMBER_OF_PC_REGISTERS=4, ROM all 0x00000000 → pc sequence 0,1,2,3,0; retired_count increments every 3 cycles.
- Reset (`rst`=0) held one cycle during WAIT_DONE → every output returns to its reset value; next `run` refetches from pc=0.
- With `ADD_WATCHDOG_EN` defined, done never asserted → error=1 exactly 255 cycles after WAIT_DONE entry. Without the macro, still waiting after 1000 cycles.
